// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
//
// Purpose:
//    Definitions shared by the N-way selector and its skid-buffered wrapper.
//    It holds the state encoding of the two-entry skid buffer and a helper
//    that computes the base bit index of one channel inside a flattened
//    M*N-bit input bus.
//
// Contents:
//    S_EMPTY / S_ONE / S_TWO : raw 2-bit state encodings
//    state_e                 : typed enum built on those encodings
//    sliceBase()             : base bit index of channel idx for width-bit words
// ----------------------------------------------------------------------------
package mux_pkg;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    // The enum reuses the raw encodings so that a waveform showing the raw
    // state bits still reads directly against the S_* constants.
    typedef enum logic [1:0] {
        STATE_EMPTY = S_EMPTY,
        STATE_ONE   = S_ONE,
        STATE_TWO   = S_TWO
    } state_e;

    // Channel idx of a flattened bus occupies bits [idx*width +: width].
    function automatic int unsigned sliceBase(input int unsigned idx,
                                              input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/nway_mux.sv
// ----------------------------------------------------------------------------
// nway_mux
//
// Purpose:
//    Purely combinational M-input, N-bit selector. Picks channel sel out of a
//    flattened input bus. A select value that names no real channel (possible
//    when M is not a power of two) falls back to channel 0 and raises oob.
//
// Ports:
//    sel     in   SELW   channel index
//    d       in   M*N    flattened inputs, channel k at d[k*N +: N]
//    y       out  N      selected word
//    ySel    out  SELW   channel the word was actually taken from
//    oob     out  1      sel was out of range (y is channel 0)
// ----------------------------------------------------------------------------
module nway_mux
    import mux_pkg::*;
#(
    parameter  int N    = 32,
    parameter  int M    = 4,
    localparam int SELW = $clog2(M)
) (
    input  logic [SELW-1:0] sel,
    input  logic [M*N-1:0]  d,
    output logic [N-1:0]    y,
    output logic [SELW-1:0] ySel,
    output logic            oob
);

    // Start from the out-of-range fallback (channel 0, flag raised) and let
    // a matching channel override it. Scanning the real channels, rather than
    // comparing sel against M, keeps the out-of-range test correct for any M
    // without a width-sensitive magnitude compare.
    always_comb begin
        y    = d[N-1:0];
        ySel = '0;
        oob  = 1'b1;
        for (int k = 0; k < M; k++) begin
            if (sel == SELW'(k)) begin
                y    = d[sliceBase(k, N) +: N];
                ySel = sel;
                oob  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/nway_mux_skid.sv
// ----------------------------------------------------------------------------
// nway_mux_skid
//
// Purpose:
//    M-input, N-bit selector followed by a registered two-entry skid buffer
//    with valid/ready handshakes on both sides. Meant for pipeline stage
//    boundaries: a downstream stall is absorbed by the skid entry, and
//    in_ready is decoded from registered state only, so there is no
//    combinational path from out_ready back to in_ready.
//
// Ports:
//    clk        in   1      clock, rising edge
//    rst        in   1      synchronous active-high reset
//    flush      in   1      synchronous clear of all buffered words
//    sel        in   SELW   channel index of the word offered upstream
//    d          in   M*N    flattened inputs, channel k at d[k*N +: N]
//    in_valid   in   1      upstream word present
//    in_ready   out  1      block can accept this cycle
//    out_data   out  N      head word
//    out_sel    out  SELW   channel the head word came from
//    out_valid  out  1      head word valid
//    out_ready  in   1      downstream accepts the head word
//    sel_err    out  1      sticky: an out-of-range sel was accepted
// ----------------------------------------------------------------------------
module nway_mux_skid
    import mux_pkg::*;
#(
    parameter  int N    = 32,
    parameter  int M    = 4,
    localparam int SELW = $clog2(M)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [SELW-1:0] sel,
    input  logic [M*N-1:0]  d,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            sel_err
);

    state_e          state_q,    state_d;
    logic [N-1:0]    mainData_q, mainData_d;
    logic [SELW-1:0] mainSel_q,  mainSel_d;
    logic [N-1:0]    skidData_q, skidData_d;
    logic [SELW-1:0] skidSel_q,  skidSel_d;
    logic            selErr_q,   selErr_d;

    logic [N-1:0]    muxData;
    logic [SELW-1:0] muxSel;
    logic            muxOob;
    logic            accept;
    logic            drain;

    // Channel selection happens before the registers, so each stored entry
    // already holds the chosen word. For an out-of-range sel the entry records
    // channel 0, the channel whose data was actually captured.
    nway_mux #(
        .N (N),
        .M (M)
    ) uMux (
        .sel  (sel),
        .d    (d),
        .y    (muxData),
        .ySel (muxSel),
        .oob  (muxOob)
    );

    // Handshake decode straight from registered state. in_ready deliberately
    // ignores out_ready: while in TWO the block refuses input even if the
    // head is draining this cycle; it reopens one cycle later.
    always_comb begin
        out_valid = (state_q != STATE_EMPTY);
        in_ready  = (state_q != STATE_TWO);
        out_data  = mainData_q;
        out_sel   = mainSel_q;
        sel_err   = selErr_q;
        accept    = in_valid && in_ready;
        drain     = out_valid && out_ready;
    end

    // Next-state and entry-update logic. The main register is always the
    // head; the skid register only fills when a word arrives while the head
    // is stalled. Flush overrides everything (the word accepted in the same
    // cycle is dropped too), but sel_err still records an out-of-range
    // select that was accepted in that cycle.
    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        mainSel_d  = mainSel_q;
        skidData_d = skidData_q;
        skidSel_d  = skidSel_q;
        selErr_d   = selErr_q | (accept & muxOob);

        if (flush) begin
            state_d = STATE_EMPTY;
        end else begin
            case (state_q)
                STATE_EMPTY: begin
                    if (accept) begin
                        state_d    = STATE_ONE;
                        mainData_d = muxData;
                        mainSel_d  = muxSel;
                    end
                end
                STATE_ONE: begin
                    if (accept && drain) begin
                        mainData_d = muxData;
                        mainSel_d  = muxSel;
                    end else if (accept) begin
                        state_d    = STATE_TWO;
                        skidData_d = muxData;
                        skidSel_d  = muxSel;
                    end else if (drain) begin
                        state_d = STATE_EMPTY;
                    end
                end
                STATE_TWO: begin
                    if (drain) begin
                        state_d    = STATE_ONE;
                        mainData_d = skidData_q;
                        mainSel_d  = skidSel_q;
                    end
                end
                default: begin
                    state_d = STATE_EMPTY;
                end
            endcase
        end
    end

    // State and entry registers. Reset clears everything, including the
    // sticky error flag, and takes priority over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= STATE_EMPTY;
            mainData_q <= '0;
            mainSel_q  <= '0;
            skidData_q <= '0;
            skidSel_q  <= '0;
            selErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            mainSel_q  <= mainSel_d;
            skidData_q <= skidData_d;
            skidSel_q  <= skidSel_d;
            selErr_q   <= selErr_d;
        end
    end

endmodule
